// File: rtl/uart_rx_os.sv
// 16x-oversampling UART receiver: 2-flop synchroniser, start-glitch rejection, 3-sample majority vote,
// framing/overrun detection, valid/ready output. Define UART_RX_PARITY_EN for an even-parity bit and ParityErr.
module uart_rx_os #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       rck,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       FrameErr,
    output logic       Overrun,
`ifdef UART_RX_PARITY_EN
    output logic       ParityErr,
`endif
    output logic       RxBusy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int CW      = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t          state;
    logic [CW-1:0]   tcnt;
    logic            tick;
    logic            rx_p0, rx_p1;
    logic            rxs;
    logic [3:0]      sc;
    logic [2:0]      bit_idx;
    logic            s7, s8;
    logic            vote;
    logic [7:0]      shreg;
    logic            par;
    logic            deliver;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return (^d) == p;
    endfunction

    assign rxs  = rx_p1;
    assign tick = (tcnt == CW'(DIV - 1));
    // Third sample is taken live, so the vote is only meaningful on the sc==9 tick.
    assign vote = vote3(s7, s8, rxs);

    always_ff @(posedge rck) begin
        if (!reset) begin
            state    <= IDLE;
            tcnt     <= '0;
            rx_p0    <= 1'b1;
            rx_p1    <= 1'b1;
            sc       <= 4'd0;
            bit_idx  <= 3'd0;
            deliver  <= 1'b0;
            RxData   <= 8'd0;
            RxValid  <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
            RxBusy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            ParityErr <= 1'b0;
`endif
        end else begin
            rx_p0    <= RxD;
            rx_p1    <= rx_p0;
            tcnt     <= tick ? '0 : tcnt + CW'(1);
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
            deliver  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            ParityErr <= 1'b0;
`endif
            if (tick) begin
                if (state != IDLE && state != BREAK)
                    sc <= sc + 4'd1;
                case (state)
                    IDLE: if (!rxs) begin
                        state  <= START;
                        sc     <= 4'd0;
                        RxBusy <= 1'b1;
                    end
                    START: begin
                        if (sc == 4'd9 && vote) begin
                            state  <= IDLE;
                            RxBusy <= 1'b0;
                        end else if (sc == 4'd15) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                    DATA: if (sc == 4'd15) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    PARITY: if (sc == 4'd15) state <= STOP;
                    // Leave at mid-stop so the next start edge is caught.
                    STOP: if (sc == 4'd9) begin
                        if (vote) begin
`ifdef UART_RX_PARITY_EN
                            if (parity_ok(shreg, par)) deliver <= 1'b1;
                            else                       ParityErr <= 1'b1;
`else
                            deliver <= 1'b1;
`endif
                            state  <= IDLE;
                            RxBusy <= 1'b0;
                        end else begin
                            FrameErr <= 1'b1;
                            state    <= BREAK;
                        end
                    end
                    BREAK: if (rxs) begin
                        state  <= IDLE;
                        RxBusy <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        RxBusy <= 1'b0;
                    end
                endcase
            end
            if (deliver) begin
                if (!RxValid || RxReady) begin
                    RxData  <= shreg;
                    RxValid <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (RxValid && RxReady) begin
                RxValid <= 1'b0;
            end
        end
    end

    // Sample capture and bit assembly carry no reset; they are always written before use.
    always_ff @(posedge rck) begin
        if (tick) begin
            if (sc == 4'd7) s7 <= rxs;
            if (sc == 4'd8) s8 <= rxs;
            if (sc == 4'd9 && state == DATA)   shreg <= {vote, shreg[7:1]};
            if (sc == 4'd9 && state == PARITY) par   <= vote;
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_par;
    assign unused_par = par ^ parity_ok(shreg, par);
`endif
endmodule
